// File: rtl/fir4_stream.sv
// Streaming 4-tap FIR with AFLV stream flags and a one-clock accept-to-output latency.
// Build option: define FIR4_SAT_EN to saturate y_out instead of wrapping the sum.
module fir4_stream #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] B0,
    input  logic [W-1:0] B1,
    input  logic [W-1:0] B2,
    input  logic [W-1:0] B3,
    input  logic [W-1:0] x_in,
    input  logic [3:0]   x_in_mflags,
    output logic [1:0]   x_in_sflags,
    output logic [W-1:0] y_out,
    output logic [3:0]   y_out_mflags,
    input  logic [1:0]   y_out_sflags
);
    localparam int SW = 2*W + 2;

    logic         stop, busy, accept, first, abort;
    logic [W-1:0] x1_q, x2_q, x3_q;
    logic [W-1:0] x1_d, x2_d, x3_d;
    logic [W-1:0] y_q, y_d;
    logic [3:0]   fl_q, fl_d;
    logic [W-1:0] y_new;

    logic [W-1:0]          coef [4];
    logic [W-1:0]          tap  [4];
    logic signed [2*W-1:0] prod [4];
    logic [SW-1:0]         acc  [5];

    assign stop        = y_out_sflags[1];
    assign busy        = y_out_sflags[0];
    assign accept      = x_in_mflags[0] & ~busy & ~stop;
    assign first       = x_in_mflags[2];
    assign abort       = x_in_mflags[3];
    assign x_in_sflags = y_out_sflags;

    assign coef[0] = B0;
    assign coef[1] = B1;
    assign coef[2] = B2;
    assign coef[3] = B3;

    // A first beat sees an empty history, so the older taps read as zero.
    assign tap[0] = x_in;
    assign tap[1] = first ? '0 : x1_q;
    assign tap[2] = first ? '0 : x2_q;
    assign tap[3] = first ? '0 : x3_q;

    assign acc[0] = '0;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_tap
            assign prod[gi]  = $signed(coef[gi]) * $signed(tap[gi]);
            assign acc[gi+1] = acc[gi] + {{2{prod[gi][2*W-1]}}, prod[gi]};
        end
    endgenerate

`ifdef FIR4_SAT_EN
    logic ovf;
    // The sum fits in W bits only when its top SW-W+1 bits are all equal.
    assign ovf   = ~((&acc[4][SW-1:W-1]) | ~(|acc[4][SW-1:W-1]));
    assign y_new = ~ovf       ? acc[4][W-1:0] :
                   acc[4][SW-1] ? {1'b1, {(W-1){1'b0}}} :
                                  {1'b0, {(W-1){1'b1}}};
`else
    logic unused_hi;
    assign unused_hi = ^acc[4][SW-1:W];
    assign y_new     = acc[4][W-1:0];
`endif

    always_comb begin
        y_d  = y_q;
        fl_d = fl_q;
        x1_d = x1_q;
        x2_d = x2_q;
        x3_d = x3_q;
        if (stop) begin
            fl_d = {fl_q[3:1], 1'b0};
            x1_d = '0;
            x2_d = '0;
            x3_d = '0;
        end else if (!busy) begin
            if (accept) begin
                y_d  = y_new;
                fl_d = x_in_mflags;
                if (abort) begin
                    x1_d = '0;
                    x2_d = '0;
                    x3_d = '0;
                end else begin
                    x1_d = x_in;
                    x2_d = first ? '0 : x1_q;
                    x3_d = first ? '0 : x2_q;
                end
            end else begin
                fl_d = {fl_q[3:1], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q  <= '0;
            fl_q <= '0;
            x1_q <= '0;
            x2_q <= '0;
            x3_q <= '0;
        end else begin
            y_q  <= y_d;
            fl_q <= fl_d;
            x1_q <= x1_d;
            x2_q <= x2_d;
            x3_q <= x3_d;
        end
    end

    assign y_out        = y_q;
    assign y_out_mflags = fl_q;
endmodule

// File: tb/tb_fir4_stream.sv
// Self-checking bench for fir4_stream: vector tables, hand sequences and a random run vs a packet-history model.
`timescale 1ns/1ps
module tb_fir4_stream;
    localparam logic [3:0] FV = 4'b0001;
    localparam logic [3:0] FL = 4'b0010;
    localparam logic [3:0] FF = 4'b0100;
    localparam logic [3:0] FA = 4'b1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] b0 = '0, b1 = '0, b2 = '0, b3 = '0, x = '0;
    logic [3:0]  fl = '0;
    logic [1:0]  sf = '0;
    logic [1:0]  x_in_sflags;
    logic [15:0] y_out;
    logic [3:0]  y_out_mflags;

    always #5 clk = ~clk;

    fir4_stream #(.W(16)) dut (
        .clk(clk), .rst(rst),
        .B0(b0), .B1(b1), .B2(b2), .B3(b3),
        .x_in(x), .x_in_mflags(fl), .x_in_sflags(x_in_sflags),
        .y_out(y_out), .y_out_mflags(y_out_mflags), .y_out_sflags(sf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: samples of the current packet, newest last; output is the dot product with B.
    longint      pkt[$];
    logic [15:0] m_y;
    logic [3:0]  m_f;

    typedef struct {
        logic [15:0] x;
        logic [3:0]  fl;
        logic [15:0] ey;
        logic [3:0]  ef;
    } vec_t;
    typedef vec_t vq_t[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_out(input longint s);
        logic [63:0] v;
`ifdef FIR4_SAT_EN
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
`endif
        v = s;
        return v[15:0];
    endfunction

    function automatic longint sx(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    task automatic model_reset();
        pkt.delete();
        m_y = '0;
        m_f = '0;
    endtask

    task automatic drive(input logic [15:0] xv, input logic [3:0] fv, input logic [1:0] sv);
        longint s;
        longint bs [4];
        x = xv; fl = fv; sf = sv;
        #1;
        check("sflags_passthru", {30'd0, x_in_sflags}, {30'd0, sv});
        bs[0] = sx(b0); bs[1] = sx(b1); bs[2] = sx(b2); bs[3] = sx(b3);
        if (sv[1]) begin
            pkt.delete();
            m_f[0] = 1'b0;
        end else if (!sv[0]) begin
            if (fv[0]) begin
                if (fv[2]) pkt.delete();
                s = bs[0] * sx(xv);
                for (int k = 1; k < 4; k++)
                    if (pkt.size() >= k) s += bs[k] * pkt[pkt.size() - k];
                m_y = ref_out(s);
                m_f = fv;
                pkt.push_back(sx(xv));
                if (pkt.size() > 3) void'(pkt.pop_front());
                if (fv[3]) pkt.delete();
            end else begin
                m_f[0] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; x = '0; fl = '0; sf = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic run_vec(input string nm, input vq_t v);
        foreach (v[i]) begin
            drive(v[i].x, v[i].fl, 2'b00);
            check({nm, "_y"}, {16'd0, y_out}, {16'd0, v[i].ey});
            check({nm, "_flags"}, {28'd0, y_out_mflags}, {28'd0, v[i].ef});
        end
    endtask

    function automatic logic [15:0] ramp_exp(input int n);
        if (n == 1) return 16'd1;
        if (n == 2) return 16'd3;
        if (n == 3) return 16'd6;
        return 16'(2 * n);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vq_t         ta, tf, tab;
        vec_t        e;
        logic [15:0] got[$];
        logic        bsy;
        int          i, cyc;

        // Reset state
        @(posedge clk);
        #1;
        check("reset_y", {16'd0, y_out}, 32'd0);
        check("reset_flags", {28'd0, y_out_mflags}, 32'd0);
        rst = 1'b0;
        model_reset();

        // Vector tables, B = (1,1,1,-1)
        for (int n = 1; n <= 15; n++) begin
            e.x  = 16'(n);
            e.fl = FV | ((n == 1) ? FF : 4'd0) | ((n == 10) ? FL : 4'd0);
            e.ey = ramp_exp(n);
            e.ef = e.fl;
            ta.push_back(e);
        end
        tf = '{'{16'd1, FF|FV, 16'd1, FF|FV}, '{16'd2, FV, 16'd3, FV}, '{16'd3, FV, 16'd6, FV},
               '{16'd4, FV, 16'd8, FV}, '{16'd5, FV, 16'd10, FV}, '{16'd6, FV, 16'd12, FV},
               '{16'd7, FV, 16'd14, FV}, '{16'd8, FF|FV, 16'd8, FF|FV}, '{16'd9, FV, 16'd17, FV},
               '{16'd10, FV, 16'd27, FV}, '{16'd11, FV, 16'd22, FV}};
        tab = '{'{16'd1, FF|FV, 16'd1, FF|FV}, '{16'd2, FV, 16'd3, FV}, '{16'd3, FV, 16'd6, FV},
                '{16'd4, FA|FV, 16'd8, FA|FV}, '{16'd5, FV, 16'd5, FV}};

        b0 = 16'd1; b1 = 16'd1; b2 = 16'd1; b3 = 16'hFFFF;
        do_reset();
        run_vec("ramp", ta);
        drive(16'd0, 4'd0, 2'b00);
        check("idle_flags", {28'd0, y_out_mflags}, 32'd0);
        check("idle_y_hold", {16'd0, y_out}, 32'd30);
        do_reset();
        run_vec("frestart", tf);
        do_reset();
        run_vec("abort", tab);

        // Stop flushes history and drops valid
        do_reset();
        drive(16'd1, FF|FV, 2'b00);
        drive(16'd2, FV, 2'b00);
        drive(16'd3, FV, 2'b00);
        drive(16'd9, FV, 2'b10);
        check("stop_flags", {28'd0, y_out_mflags}, 32'd0);
        check("stop_y_hold", {16'd0, y_out}, 32'd6);
        drive(16'd4, FV, 2'b00);
        check("after_stop_y", {16'd0, y_out}, 32'd4);

        // Busy toggling: exactly one consumed output per input
        do_reset();
        i = 1; cyc = 0;
        while (i <= 15 && cyc < 200) begin
            bsy = (cyc % 12) >= 10;
            if (y_out_mflags[0] && !bsy) got.push_back(y_out);
            drive(16'(i), FV | ((i == 1) ? FF : 4'd0), {1'b0, bsy});
            if (!bsy) i++;
            cyc++;
        end
        for (int k = 0; k < 2; k++) begin
            if (y_out_mflags[0]) got.push_back(y_out);
            drive(16'd0, 4'd0, 2'b00);
        end
        check("busy_count", got.size(), 32'd15);
        foreach (got[k]) check("busy_seq", {16'd0, got[k]}, {16'd0, ramp_exp(k + 1)});

        // Overflow handling
        do_reset();
        b0 = 16'h7FFF; b1 = 16'h7FFF; b2 = 16'd0; b3 = 16'd0;
        drive(16'h7FFF, FF|FV, 2'b00);
`ifdef FIR4_SAT_EN
        check("ovf_pos1", {16'd0, y_out}, 32'h7FFF);
`else
        check("ovf_pos1", {16'd0, y_out}, 32'h0001);
`endif
        drive(16'h7FFF, FV, 2'b00);
`ifdef FIR4_SAT_EN
        check("ovf_pos2", {16'd0, y_out}, 32'h7FFF);
`else
        check("ovf_pos2", {16'd0, y_out}, 32'h0002);
`endif
        b0 = 16'h8000; b1 = 16'h8000;
        drive(16'h7FFF, FF|FV, 2'b00);
        check("ovf_neg1", {16'd0, y_out}, 32'h8000);
        drive(16'h7FFF, FV, 2'b00);
`ifdef FIR4_SAT_EN
        check("ovf_neg2", {16'd0, y_out}, 32'h8000);
`else
        check("ovf_neg2", {16'd0, y_out}, 32'h0000);
`endif

        // Asynchronous reset mid-stream
        b0 = 16'd1; b1 = 16'd1; b2 = 16'd1; b3 = 16'hFFFF;
        drive(16'd1, FF|FV, 2'b00);
        drive(16'd2, FV, 2'b00);
        drive(16'd3, FV, 2'b00);
        #3 rst = 1'b1;
        #1;
        check("async_rst_y", {16'd0, y_out}, 32'd0);
        check("async_rst_flags", {28'd0, y_out_mflags}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        drive(16'd5, FV, 2'b00);
        check("post_rst_y", {16'd0, y_out}, 32'd5);
        check("post_rst_flags", {28'd0, y_out_mflags}, {28'd0, FV});

        // Randomized run against the reference model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            logic [3:0] fv;
            logic [1:0] sv;
            if (n % 50 == 0) begin
                b0 = 16'($urandom); b1 = 16'($urandom);
                b2 = 16'($urandom); b3 = 16'($urandom);
            end
            fv[0] = ($urandom % 4) != 0;
            fv[1] = ($urandom % 5) == 0;
            fv[2] = ($urandom % 8) == 0;
            fv[3] = ($urandom % 16) == 0;
            sv[0] = ($urandom % 4) == 0;
            sv[1] = ($urandom % 16) == 0;
            drive(16'($urandom), fv, sv);
            check("rand_y", {16'd0, y_out}, {16'd0, m_y});
            check("rand_flags", {28'd0, y_out_mflags}, {28'd0, m_f});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
